mem_arbiter: RTL and testbench

//  Shares one single-port data memory (comb. read, write on clk edge when wen=1) between two requesters:

---
 rtl/mem_arb_pkg.sv | 13 +
 rtl/mem_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_arbiter.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings for mem_arbiter: FSM state values and requester port indices.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic P_IFETCH = 1'b0;
    localparam logic P_DATA   = 1'b1;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a slow single-port memory with a fixed access latency.
// Define ARB_RR_EN for round-robin tie-breaking; otherwise the data port wins every tie.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned BITS    = 64,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              wen0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [BITS-1:0]   wdata0,
    output logic              ready0,
    input  logic              req1,
    input  logic              wen1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [BITS-1:0]   wdata1,
    output logic              ready1,
    output logic [BITS-1:0]   rdata,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BITS-1:0]   mem_wdata,
    input  logic [BITS-1:0]   mem_rdata,
    output logic              busy
);

    localparam int unsigned CntW = $clog2(LATENCY + 1);

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              gnt_q, gnt_d;
    logic              last_grant_q, last_grant_d;
    logic              wen_q, wen_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [BITS-1:0]   mem_wdata_q, mem_wdata_d;
    logic [BITS-1:0]   rdata_q, rdata_d;
    logic              ready0_q, ready0_d;
    logic              ready1_q, ready1_d;
    logic              win;

    always_comb begin
`ifdef ARB_RR_EN
        if (req0 && req1) begin
            win = ~last_grant_q;
        end else begin
            win = req1 ? P_DATA : P_IFETCH;
        end
`else
        win = req1 ? P_DATA : P_IFETCH;
`endif
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        gnt_d        = gnt_q;
        last_grant_d = last_grant_q;
        wen_d        = wen_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        rdata_d      = rdata_q;
        ready0_d     = 1'b0;
        ready1_d     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    gnt_d       = win;
                    wen_d       = (win == P_DATA) ? wen1 : wen0;
                    mem_addr_d  = (win == P_DATA) ? addr1 : addr0;
                    mem_wdata_d = (win == P_DATA) ? wdata1 : wdata0;
                    cnt_d       = CntW'(LATENCY - 1);
                    state_d     = S_BUSY;
                end
            end
            S_BUSY: begin
                if (cnt_q == '0) begin
                    // A write echoes its own data so rdata is always defined at ready.
                    rdata_d  = wen_q ? mem_wdata_q : mem_rdata;
                    ready0_d = (gnt_q == P_IFETCH);
                    ready1_d = (gnt_q == P_DATA);
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                last_grant_d = gnt_q;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            gnt_q        <= 1'b0;
            last_grant_q <= 1'b1;
            wen_q        <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rdata_q      <= '0;
            ready0_q     <= 1'b0;
            ready1_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            gnt_q        <= gnt_d;
            last_grant_q <= last_grant_d;
            wen_q        <= wen_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            rdata_q      <= rdata_d;
            ready0_q     <= ready0_d;
            ready1_q     <= ready1_d;
        end
    end

    // Combinational so an async reset kills an in-flight write immediately.
    assign mem_wen   = (state_q == S_BUSY) && (cnt_q == '0) && wen_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign rdata     = rdata_q;
    assign ready0    = ready0_q;
    assign ready1    = ready1_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (LATENCY=4 and LATENCY=1 instances).
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, wen0, req1, wen1, ready0, ready1, mem_wen, busy;
    logic [7:0]  addr0, addr1, mem_addr;
    logic [63:0] wdata0, wdata1, rdata, mem_wdata, mem_rdata;

    logic        f_req0, f_ready0, f_ready1, f_mem_wen, f_busy;
    logic [7:0]  f_addr0, f_mem_addr;
    logic [63:0] f_rdata, f_mem_wdata, f_mem_rdata;

    logic [63:0] mem [256];
    int          checks = 0;
    int          errors = 0;

    localparam logic [63:0] Pat = 64'hC0DE_0000_0000_0000;

    always #5 clk = ~clk;

    assign mem_rdata   = mem[mem_addr];
    assign f_mem_rdata = mem[f_mem_addr];

    always @(posedge clk) begin
        if (mem_wen) mem[mem_addr] = mem_wdata;
    end

    mem_arbiter #(.BITS(64), .ADDR_W(8), .LATENCY(4)) u_dut (
        .clk(clk), .rst(rst),
        .req0(req0), .wen0(wen0), .addr0(addr0), .wdata0(wdata0), .ready0(ready0),
        .req1(req1), .wen1(wen1), .addr1(addr1), .wdata1(wdata1), .ready1(ready1),
        .rdata(rdata), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_arbiter #(.BITS(64), .ADDR_W(8), .LATENCY(1)) u_fast (
        .clk(clk), .rst(rst),
        .req0(f_req0), .wen0(1'b0), .addr0(f_addr0), .wdata0(64'h0), .ready0(f_ready0),
        .req1(1'b0), .wen1(1'b0), .addr1(8'h00), .wdata1(64'h0), .ready1(f_ready1),
        .rdata(f_rdata), .mem_wen(f_mem_wen), .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata),
        .mem_rdata(f_mem_rdata), .busy(f_busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!(ready0 || ready1) && n < 40);
    endtask

    task automatic wait_fast(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!f_ready0 && n < 40);
    endtask

    initial begin
        int   n;
        int   idle;
        logic exp1;

        for (int i = 0; i < 256; i++) mem[i] = Pat | 64'(i);
        rst = 1'b1;
        req0 = 0; wen0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; wen1 = 0; addr1 = 0; wdata1 = 0;
        f_req0 = 0; f_addr0 = 0;
        step();
        step();
        check("rst_ready0", ready0, 0);
        check("rst_ready1", ready1, 0);
        check("rst_mem_wen", mem_wen, 0);
        check("rst_busy", busy, 0);
        check("rst_rdata", rdata, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        rst = 1'b0;

        // Test 1: reset in the last BUSY cycle of a write aborts it.
        req1 = 1; wen1 = 1; addr1 = 8'h10; wdata1 = 64'hDEAD;
        step();
        check("t1_busy", busy, 1);
        check("t1_mem_addr", mem_addr, 8'h10);
        check("t1_wen_early", mem_wen, 0);
        step(); step(); step();
        check("t1_wen_last", mem_wen, 1);
        rst = 1'b1;
        #1;
        check("t1_wen_rst", mem_wen, 0);
        check("t1_busy_rst", busy, 0);
        req1 = 0; wen1 = 0;
        step();
        check("t1_ready1", ready1, 0);
        step();
        rst = 1'b0;
        step();
        check("t1_no_ready", {ready0, ready1}, 0);
        check("t1_mem16", mem[16], Pat | 64'h10);

        // Test 2: port 1 write, then port 0 reads it back.
        req1 = 1; wen1 = 1; addr1 = 8'h03; wdata1 = 64'hA5A5;
        step(); step(); step();
        check("t2_wen_c3", mem_wen, 0);
        step();
        check("t2_wen_c4", mem_wen, 1);
        step();
        check("t2_ready1", ready1, 1);
        check("t2_ready0_lo", ready0, 0);
        check("t2_wen_c5", mem_wen, 0);
        check("t2_rdata_wr", rdata, 64'hA5A5);
        req1 = 0; wen1 = 0;
        step();
        check("t2_idle", busy, 0);
        check("t2_ready1_pulse", ready1, 0);
        req0 = 1; wen0 = 0; addr0 = 8'h03;
        wait_ready(n);
        check("t2_lat0", n, 5);
        check("t2_ready0", ready0, 1);
        check("t2_rdata_rd", rdata, 64'hA5A5);
        req0 = 0;
        step();

        // Test 4: address change during BUSY has no effect.
        req1 = 1; wen1 = 0; addr1 = 8'h40;
        step();
        addr1 = 8'h41;
        step();
        check("t4_mem_addr", mem_addr, 8'h40);
        wait_ready(n);
        check("t4_lat", n, 3);
        check("t4_ready1", ready1, 1);
        check("t4_rdata", rdata, Pat | 64'h40);
        req1 = 0;
        step();

        // Test 5: LATENCY=1 back-to-back reads.
        f_req0 = 1; f_addr0 = 8'h00;
        for (int k = 0; k < 3; k++) begin
            wait_fast(n);
            check("t5_lat", n, (k == 0) ? 2 : 3);
            check("t5_rdata", f_rdata, Pat | 64'(k));
            f_addr0 = 8'(k + 1);
        end
        f_req0 = 0;
        step();

        // Tests 3/6: continuous ties for 20 accesses from a fresh reset.
        rst = 1'b1;
        step();
        rst = 1'b0;
        req0 = 1; wen0 = 0; addr0 = 8'h20;
        req1 = 1; wen1 = 0; addr1 = 8'h21;
        for (int k = 0; k < 20; k++) begin
            n = 0;
            idle = 0;
            do begin
                step();
                n++;
                if (!busy) idle++;
            end while (!(ready0 || ready1) && n < 40);
`ifdef ARB_RR_EN
            exp1 = (k % 2 == 1);
`else
            exp1 = 1'b1;
`endif
            check("t6_interval", n, (k == 0) ? 5 : 6);
            check("t6_idle_gap", idle, (k == 0) ? 0 : 1);
            check("t3_ready1", ready1, exp1);
            check("t3_ready0", ready0, !exp1);
            check("t3_rdata", rdata, exp1 ? (Pat | 64'h21) : (Pat | 64'h20));
        end
        req0 = 0;
        req1 = 0;
        step();
        step();
        check("end_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
